// File: rtl/song_sequencer_pkg.sv
// Shared constants, state encoding and song numbers for the song sequencer.
package song_sequencer_pkg;

  localparam int unsigned DEF_SONG_LEN   = 26;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_NOTE_W     = 4;
  localparam int unsigned DEF_DUR_W      = 26;
  localparam int unsigned DEF_GAP_CYCLES = 5000000;
  localparam int unsigned SONG_W         = 2;

  localparam logic [SONG_W-1:0] SONG_NONE = 2'd0;
  localparam logic [SONG_W-1:0] SONG_1    = 2'd1;
  localparam logic [SONG_W-1:0] SONG_2    = 2'd2;
  localparam logic [SONG_W-1:0] SONG_3    = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_WAIT  = ST_WAIT,
    S_PLAY  = ST_PLAY,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/song_sequencer_note_timer.sv
// Loadable down-counter; expire_o is high in the cycle the count reads 1.
module song_sequencer_note_timer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned DUR_W = DEF_DUR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DUR_W-1:0] value_i,
  output logic             expire_o
);

  logic [DUR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - DUR_W'(1);
    end
  end

  // Expire is registered from the next count so it lines up with count_q == 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      expire_o <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_o <= (count_d == DUR_W'(1));
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks one stored song note by note, holding each for its stored duration plus a silent gap.
// Build option: SONG_SEQ_LOOP_EN repeats the song forever, pulsing done once per pass.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned SONG_LEN   = DEF_SONG_LEN,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned NOTE_W     = DEF_NOTE_W,
  parameter int unsigned DUR_W      = DEF_DUR_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [SONG_W-1:0] song_sel_i,
  output logic              mem_isread_o,
  output logic [SONG_W-1:0] mem_songnum_o,
  output logic [ADDR_W-1:0] mem_location_o,
  input  logic [NOTE_W-1:0] mem_note_i,
  input  logic [DUR_W-1:0]  mem_duration_i,
  output logic [NOTE_W-1:0] note_out_o,
  output logic              note_valid_o,
  output logic              playing_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] cur_index_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);
  localparam logic [DUR_W-1:0]  GAP_LOAD = DUR_W'(GAP_CYCLES);
  localparam bit                GAP_EN   = (GAP_CYCLES != 0);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              done_d;
  logic              advance;
  logic              tmr_load;
  logic [DUR_W-1:0]  tmr_load_val;
  logic              tmr_expire;

  song_sequencer_note_timer #(
    .DUR_W (DUR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_load_val),
    .expire_o (tmr_expire)
  );

  // Next-state logic; stop is applied last so it overrides every transition.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    song_d       = song_q;
    note_d       = note_q;
    done_d       = 1'b0;
    advance      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = mem_duration_i;

    case (state_q)
      S_IDLE: begin
        if (start_i && (song_sel_i != SONG_NONE)) begin
          song_d  = song_sel_i;
          index_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_duration_i == '0) begin
          advance = 1'b1;
        end else begin
          note_d   = mem_note_i;
          tmr_load = 1'b1;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tmr_expire) begin
          if (GAP_EN) begin
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
            state_d      = S_GAP;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tmr_expire) begin
          advance = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (index_q == LAST_IDX) begin
`ifdef SONG_SEQ_LOOP_EN
        index_d = '0;
        state_d = S_FETCH;
        done_d  = 1'b1;
`else
        state_d = S_DONE;
        done_d  = 1'b1;
`endif
      end else begin
        index_d = index_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end

    if (stop_i) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      song_q       <= '0;
      note_q       <= '0;
      mem_isread_o <= 1'b0;
      note_valid_o <= 1'b0;
      playing_o    <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      song_q       <= song_d;
      note_q       <= note_d;
      mem_isread_o <= (state_d == S_FETCH) || (state_d == S_WAIT);
      note_valid_o <= (state_d == S_PLAY);
      playing_o    <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_o       <= done_d;
    end
  end

  assign mem_songnum_o  = song_q;
  assign mem_location_o = index_q;
  assign cur_index_o    = index_q;
  assign note_out_o     = note_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 1-cycle registered song memory model,
// SONG_LEN=4 and GAP_CYCLES=2. Honours SONG_SEQ_LOOP_EN when defined.
module tb_song_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 26;
`ifdef SONG_SEQ_LOOP_EN
  localparam int LOOP = 1;
`else
  localparam int LOOP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [1:0]        song_sel;
  logic              mem_isread;
  logic [1:0]        mem_songnum;
  logic [ADDR_W-1:0] mem_location;
  logic [NOTE_W-1:0] mem_note;
  logic [DUR_W-1:0]  mem_duration;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic              playing;
  logic              done;
  logic [ADDR_W-1:0] cur_index;

  logic [NOTE_W-1:0] note_tab [4][32];
  logic [DUR_W-1:0]  dur_tab  [4][32];

  int n_checks = 0;
  int n_errors = 0;

  int run_start[$];
  int run_note[$];
  int run_len[$];
  int fetch_loc[$];
  int done_cnt;
  int done_k;
  logic prev_valid;

  song_sequencer #(
    .SONG_LEN   (4),
    .ADDR_W     (ADDR_W),
    .NOTE_W     (NOTE_W),
    .DUR_W      (DUR_W),
    .GAP_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .stop_i         (stop),
    .song_sel_i     (song_sel),
    .mem_isread_o   (mem_isread),
    .mem_songnum_o  (mem_songnum),
    .mem_location_o (mem_location),
    .mem_note_i     (mem_note),
    .mem_duration_i (mem_duration),
    .note_out_o     (note_out),
    .note_valid_o   (note_valid),
    .playing_o      (playing),
    .done_o         (done),
    .cur_index_o    (cur_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_isread) begin
      mem_note     <= note_tab[mem_songnum][mem_location];
      mem_duration <= dur_tab[mem_songnum][mem_location];
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    run_start.delete();
    run_note.delete();
    run_len.delete();
    fetch_loc.delete();
    done_cnt   = 0;
    done_k     = -1;
    prev_valid = 1'b0;
  endtask

  // k = number of clock edges since start was sampled
  task automatic sample(input int k);
    if (mem_isread) fetch_loc.push_back(int'(mem_location));
    if (note_valid) begin
      if (!prev_valid) begin
        run_start.push_back(k);
        run_note.push_back(int'(note_out));
        run_len.push_back(1);
      end else begin
        run_len[run_len.size()-1]++;
      end
    end
    if (done) begin
      done_cnt++;
      done_k = k;
    end
    prev_valid = note_valid;
  endtask

  task automatic observe(input int n, input int k0);
    for (int k = k0; k < k0 + n; k++) begin
      tick;
      sample(k);
    end
  endtask

  task automatic check_runs(input string tag, input int n,
                            input int es[4], input int en[4], input int el[4]);
    check_eq({tag, "_runs"}, run_start.size(), n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_start%0d", tag, i), run_start[i], es[i]);
      check_eq($sformatf("%s_note%0d", tag, i), run_note[i], en[i]);
      check_eq($sformatf("%s_len%0d", tag, i), run_len[i], el[i]);
    end
  endtask

  task automatic check_fetch(input string tag);
    int exp_loc[10];
    exp_loc = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    check_eq({tag, "_fetch_cnt"}, fetch_loc.size(), 8 + 2 * LOOP);
    for (int i = 0; i < fetch_loc.size() && i < 10; i++) begin
      check_eq($sformatf("%s_fetch%0d", tag, i), fetch_loc[i], exp_loc[i]);
    end
  endtask

  task automatic start_song(input logic [1:0] sel);
    song_sel = sel;
    start    = 1'b1;
    tick;
    start    = 1'b0;
    clear_log;
    sample(1);
  endtask

  task automatic stop_cleanup;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check_eq("cleanup_playing", int'(playing), 0);
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      for (int l = 0; l < 32; l++) begin
        note_tab[s][l] = '0;
        dur_tab[s][l]  = '0;
      end
    end
    note_tab[1][0] = 4'd2;  note_tab[1][1] = 4'd2;  note_tab[1][2] = 4'd3;  note_tab[1][3] = 4'd4;
    dur_tab[1][0]  = 26'd5; dur_tab[1][1]  = 26'd5; dur_tab[1][2]  = 26'd5; dur_tab[1][3]  = 26'd8;
    note_tab[2][0] = 4'd5;  note_tab[2][1] = 4'd6;  note_tab[2][2] = 4'd7;  note_tab[2][3] = 4'd8;
    dur_tab[2][0]  = 26'd3; dur_tab[2][1]  = 26'd0; dur_tab[2][2]  = 26'd2; dur_tab[2][3]  = 26'd1;
    note_tab[3][0] = 4'd9;  note_tab[3][1] = 4'd10; note_tab[3][2] = 4'd11; note_tab[3][3] = 4'd12;
    dur_tab[3][0]  = 26'd4; dur_tab[3][1]  = 26'd4; dur_tab[3][2]  = 26'd4; dur_tab[3][3]  = 26'd4;

    rst = 1'b1; start = 1'b0; stop = 1'b0; song_sel = 2'd0;
    tick;
    tick;
    rst = 1'b0;
    check_eq("rst_playing", int'(playing), 0);
    check_eq("rst_valid", int'(note_valid), 0);
    check_eq("rst_isread", int'(mem_isread), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_index", int'(cur_index), 0);
    check_eq("rst_note", int'(note_out), 0);
    check_eq("rst_songnum", int'(mem_songnum), 0);

    // Song 1: fetch timing, note/gap lengths, single done pulse.
    start_song(2'd1);
    check_eq("s1_k1_isread", int'(mem_isread), 1);
    check_eq("s1_k1_loc", int'(mem_location), 0);
    check_eq("s1_k1_song", int'(mem_songnum), 1);
    check_eq("s1_k1_playing", int'(playing), 1);
    check_eq("s1_k1_valid", int'(note_valid), 0);
    tick; sample(2);
    check_eq("s1_k2_isread", int'(mem_isread), 1);
    check_eq("s1_k2_valid", int'(note_valid), 0);
    tick; sample(3);
    check_eq("s1_k3_valid", int'(note_valid), 1);
    check_eq("s1_k3_note", int'(note_out), 2);
    check_eq("s1_k3_isread", int'(mem_isread), 0);
    observe(38, 4);
    check_runs("s1", 4, '{3, 12, 21, 30}, '{2, 2, 3, 4}, '{5, 5, 5, 8});
    check_fetch("s1");
    check_eq("s1_done_cnt", done_cnt, 1);
    check_eq("s1_done_k", done_k, 40);
    check_eq("s1_end_playing", int'(playing), LOOP);
    stop_cleanup;

    // Song 2: zero duration at location 1 is skipped.
    start_song(2'd2);
    observe(21, 2);
    check_runs("s2", 3, '{3, 12, 18, 0}, '{5, 7, 8, 0}, '{3, 2, 1, 0});
    check_fetch("s2");
    check_eq("s2_done_cnt", done_cnt, 1);
    check_eq("s2_done_k", done_k, 21);
    check_eq("s2_end_playing", int'(playing), LOOP);
    stop_cleanup;

    // Song 3: start during playback ignored, then stop during location 2.
    start_song(2'd3);
    for (int k = 2; k <= 20; k++) begin
      tick;
      sample(k);
      if (k == 5) begin
        start = 1'b1;
        song_sel = 2'd1;
      end
      if (k == 6) start = 1'b0;
      if (k == 10) begin
        check_eq("s3_k10_loc", int'(mem_location), 1);
        check_eq("s3_k10_song", int'(mem_songnum), 3);
      end
    end
    check_eq("s3_k20_valid", int'(note_valid), 1);
    check_eq("s3_k20_note", int'(note_out), 11);
    check_eq("s3_runs", run_start.size(), 3);
    check_eq("s3_run1_start", run_start[1], 11);
    check_eq("s3_run1_note", run_note[1], 10);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check_eq("stop_valid", int'(note_valid), 0);
    check_eq("stop_playing", int'(playing), 0);
    check_eq("stop_isread", int'(mem_isread), 0);
    check_eq("stop_done", int'(done), 0);
    clear_log;
    observe(30, 22);
    check_eq("stop_after_done", done_cnt, 0);
    check_eq("stop_after_runs", run_start.size(), 0);
    check_eq("stop_after_fetch", fetch_loc.size(), 0);

    // song_sel = 0 is ignored.
    start_song(2'd0);
    observe(5, 2);
    check_eq("sel0_playing", int'(playing), 0);
    check_eq("sel0_fetch", fetch_loc.size(), 0);

    // Simultaneous start and stop in IDLE: stop wins.
    stop = 1'b1;
    start_song(2'd1);
    stop = 1'b0;
    check_eq("ss_playing", int'(playing), 0);
    check_eq("ss_isread", int'(mem_isread), 0);
    observe(4, 2);
    check_eq("ss_fetch", fetch_loc.size(), 0);

    // Reset mid-song.
    start_song(2'd1);
    observe(9, 2);
    check_eq("mr_k10_index", int'(cur_index), 1);
    check_eq("mr_k10_isread", int'(mem_isread), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("mr_playing", int'(playing), 0);
    check_eq("mr_index", int'(cur_index), 0);
    check_eq("mr_note", int'(note_out), 0);
    check_eq("mr_songnum", int'(mem_songnum), 0);
    check_eq("mr_isread", int'(mem_isread), 0);
    clear_log;
    observe(40, 1);
    check_eq("mr_after_done", done_cnt, 0);
    check_eq("mr_after_runs", run_start.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
